fifo: RTL and testbench

- Synchronous single-clock byte FIFO used as the transmit buffer in front of the UART transmitter.
- The producer pushes bytes with a write strobe. The transmitter pops one byte per frame with a read strobe.
- Both strobes may be held high for many clock cycles, so each strobe acts only on its rising edge.
- The popped byte is presented on a registered output and held until the next pop.

---
 rtl/fifo.sv | 131 +++++++++++++
 tb/tb_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo: synchronous single-clock byte FIFO. It is the transmit buffer that sits
// in front of the UART transmitter.
//
// The producer and the transmitter drive level strobes. These strobes may stay
// high for many cycles, so only the rising edge of each strobe is acted on.
// A pop places the head word on data_out, which is a register. data_out keeps
// that value until the next accepted pop.
//
// Parameters
//   DATA_WIDTH : width of each stored word
//   ADDR_WIDTH : pointer width; depth = 2**ADDR_WIDTH
//
// Ports
//   clk      in   system clock; all logic runs on the rising edge
//   rst      in   synchronous, active-high reset
//   data_in  in   word stored on an accepted push
//   data_out out  registered; the last popped word
//   wr       in   push strobe; a rising edge requests one push
//   rd       in   pop strobe; a rising edge requests one pop
//   full     out  registered; high when the FIFO holds depth words
//   empty    out  registered; high when the FIFO holds no words
// -----------------------------------------------------------------------------
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The count needs one more bit than a pointer so that it can hold DEPTH.
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  wr_d;
    logic                  rd_d;
    logic                  push_req;
    logic                  pop_req;
    logic                  push_ok;
    logic                  pop_ok;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Strobe history. These registers keep sampling while reset is asserted.
    // A strobe that is still high when reset is released therefore looks
    // "already seen", and it raises no request until it falls and rises again.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so that every register
        // samples its pre-edge value, whatever the order of the statements.
        wr_d <= wr;
        rd_d <= rd;
    end

    // Request qualification and next-count computation.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so that no
        // path through the block leaves a value unassigned and infers a latch.
        push_req   = 1'b0;
        pop_req    = 1'b0;
        pop_ok     = 1'b0;
        push_ok    = 1'b0;
        count_next = count;

        push_req = wr & ~wr_d;
        pop_req  = rd & ~rd_d;

        // Requests that arrive in the reset cycle are dropped.
        pop_ok  = pop_req & ~empty & ~rst;

        // A full FIFO can still accept a push when a pop happens in the same
        // cycle. The pop frees the head slot, and the write pointer points at
        // that slot. The read uses the old contents because mem is read
        // before the edge on which it is written.
        push_ok = push_req & (~full | pop_ok) & ~rst;

        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array.
    always_ff @(posedge clk) begin
        // NOTE: the memory has no reset. Its contents are don't-care after
        // reset because the pointers and the count define what is valid.
        // Leaving it unreset lets it map onto RAM primitives.
        if (push_ok) begin
            mem[wptr] <= data_in;
        end
    end

    // Pointers, count, output register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            // The pointers wrap by natural ADDR_WIDTH-bit rollover.
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                data_out <= mem[rptr];
                rptr     <= rptr + 1'b1;
            end
            count <= count_next;
            // The flags are registered from the next count. They are
            // therefore valid on the cycle after the operation that changed
            // the count.
            full  <= (count_next == COUNT_FULL);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo: directed, self-checking bench for fifo.
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       wr;
    logic       rd;
    logic       full;
    logic       empty;

    int checks = 0;
    int passed = 0;

    fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .wr       (wr),
        .rd       (rd),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle push pulse, followed by one low cycle to re-arm the edge.
    task automatic push(input logic [7:0] d);
        data_in = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
    endtask

    // Single-cycle pop pulse. data_out is checked by the caller after the
    // pulse. The low cycle that follows leaves data_out unchanged.
    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; data_in = 8'h00;
        #1;

        // Reset
        tick(); tick();
        check("reset_empty", {7'd0, empty}, 8'd1);
        check("reset_full", {7'd0, full}, 8'd0);
        check("reset_dout", data_out, 8'h00);
        rst = 1'b0;
        tick();
        pop();
        check("pop_empty_dout", data_out, 8'h00);
        check("pop_empty_empty", {7'd0, empty}, 8'd1);

        // Level strobe: one push and one pop per held level
        data_in = 8'hA5;
        wr = 1'b1;
        repeat (100) tick();
        check("held_wr_empty", {7'd0, empty}, 8'd0);
        check("held_wr_full", {7'd0, full}, 8'd0);
        wr = 1'b0;
        tick();
        rd = 1'b1;
        tick();
        check("held_rd_dout", data_out, 8'hA5);
        check("held_rd_empty", {7'd0, empty}, 8'd1);
        repeat (49) tick();
        rd = 1'b0;
        tick();
        rd = 1'b1;
        repeat (10) tick();
        rd = 1'b0;
        tick();
        check("second_rd_dout", data_out, 8'hA5);
        check("second_rd_empty", {7'd0, empty}, 8'd1);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            if (i == 14) check("fill_not_full_15", {7'd0, full}, 8'd0);
        end
        check("fill_full", {7'd0, full}, 8'd1);
        push(8'hFF);
        check("overflow_full", {7'd0, full}, 8'd1);
        for (int i = 0; i < 16; i++) begin
            pop();
            check($sformatf("drain_%0d", i), data_out, 8'(i));
            if (i == 0) check("drain_not_full", {7'd0, full}, 8'd0);
            if (i == 14) check("drain_not_empty", {7'd0, empty}, 8'd0);
        end
        check("drain_empty", {7'd0, empty}, 8'd1);

        // Wrap-around
        for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            pop();
            check($sformatf("pre_wrap_%0d", i), data_out, 8'h50 + 8'(i));
        end
        for (int i = 0; i < 12; i++) begin
            push(8'h20 + 8'(i));
            check($sformatf("wrap_nofull_%0d", i), {7'd0, full}, 8'd0);
        end
        for (int i = 0; i < 12; i++) begin
            pop();
            check($sformatf("wrap_pop_%0d", i), data_out, 8'h20 + 8'(i));
        end
        check("wrap_empty", {7'd0, empty}, 8'd1);

        // Simultaneous push and pop with 3 entries
        push(8'h11); push(8'h22); push(8'h33);
        data_in = 8'h44; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("simul_dout", data_out, 8'h11);
        tick();
        pop(); check("simul_pop1", data_out, 8'h22);
        pop(); check("simul_pop2", data_out, 8'h33);
        check("simul_not_empty", {7'd0, empty}, 8'd0);
        pop(); check("simul_pop3", data_out, 8'h44);
        check("simul_empty", {7'd0, empty}, 8'd1);

        // Simultaneous push and pop while full
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
        check("full_before_simul", {7'd0, full}, 8'd1);
        data_in = 8'h77; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("full_simul_dout", data_out, 8'h60);
        check("full_simul_full", {7'd0, full}, 8'd1);
        tick();
        for (int i = 1; i < 16; i++) begin
            pop();
            check($sformatf("full_simul_pop_%0d", i), data_out, 8'h60 + 8'(i));
        end
        pop();
        check("full_simul_last", data_out, 8'h77);
        check("full_simul_empty", {7'd0, empty}, 8'd1);

        // Simultaneous push and pop while empty
        data_in = 8'h88; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("empty_simul_empty", {7'd0, empty}, 8'd0);
        check("empty_simul_dout", data_out, 8'h77);
        tick();
        pop();
        check("empty_simul_pop", data_out, 8'h88);
        check("empty_simul_after", {7'd0, empty}, 8'd1);

        // Reset mid-operation with a push edge in the reset cycle
        for (int i = 0; i < 5; i++) push(8'h90 + 8'(i));
        check("mid_not_empty", {7'd0, empty}, 8'd0);
        data_in = 8'hAA; wr = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_empty", {7'd0, empty}, 8'd1);
        check("mid_rst_full", {7'd0, full}, 8'd0);
        check("mid_rst_dout", data_out, 8'h00);
        repeat (3) tick();
        check("held_through_rst", {7'd0, empty}, 8'd1);
        wr = 1'b0;
        tick();
        wr = 1'b1;
        tick();
        check("rearmed_push", {7'd0, empty}, 8'd0);
        wr = 1'b0;
        tick();
        pop();
        check("rearmed_pop", data_out, 8'hAA);
        check("rearmed_empty", {7'd0, empty}, 8'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
